// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: op codes, address map,
// FSM state encoding and the store-lane helpers.
package mem_access_unit_pkg;

    // M_MemOp encodings; anything outside 1..8 behaves as no operation.
    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;

    // Address map: data memory starts at zero, device window is word-only.
    localparam logic [31:0] DM_LAST  = 32'h0000_2FFF;
    localparam logic [31:0] DEV_BASE = 32'h0000_7F00;
    localparam logic [31:0] DEV_LAST = 32'h0000_7F1B;
    // Timer count registers are read-only.
    localparam logic [31:0] RO_CNT0  = 32'h0000_7F08;
    localparam logic [31:0] RO_CNT1  = 32'h0000_7F18;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd2
    } width_e;

    // Access width of an op; no-op codes report word (they never issue).
    function automatic width_e op_width(input logic [3:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return W_HALF;
            OP_LB, OP_LBU, OP_SB: return W_BYTE;
            default:              return W_WORD;
        endcase
    endfunction

    // Byte enables on the bus; loads always read the full word.
    function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            OP_SH:   return lo[1] ? 4'b1100 : 4'b0011;
            OP_SB:   return 4'b0001 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across lanes so the byte enables pick the lane.
    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wdata);
        case (op)
            OP_SW:   return wdata;
            OP_SH:   return {2{wdata[15:0]}};
            OP_SB:   return {4{wdata[7:0]}};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory / device bus between the access unit (master) and memory (slave).
// Handshake: the master raises bus_req with addr/we/be/wdata stable and keeps
// them stable until it samples bus_ack=1 on a rising edge; that edge completes
// the transfer and bus_rdata is valid in the same cycle as bus_ack. The slave
// must not assert bus_ack while bus_req is low; the master ignores it if it does.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_load_ext.sv
// Load data extraction: picks the byte/half addressed by addr[1:0] out of the
// returned word and sign- or zero-extends it to 32 bits.
module mem_load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane select then extension; non-load ops produce zero.
    always_comb begin
        sel_byte = rdata[{addr, 3'b000} +: 8];
        sel_half = addr[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LW:   data = rdata;
            OP_LH:   data = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  data = {16'h0, sel_half};
            OP_LB:   data = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  data = {24'h0, sel_byte};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage memory access unit: decodes address exceptions combinationally,
// runs one bus transfer per access and stalls the pipeline until it completes.
// Result is presented on M_DMRD for exactly one cycle (DONE).
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  M_MemOp,
    input  logic [31:0] M_Addr,
    input  logic [31:0] M_WData,
    output logic [31:0] M_DMRD,
    output logic        M_Stall,
    output logic        M_ExcAdEL,
    output logic        M_ExcAdES,
    output logic [1:0]  state_dbg,
    mem_access_unit_if.master bus
);

    logic [1:0]  state;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [3:0]  op_q;
    logic [1:0]  lo_q;
    logic [31:0] data_q;
    logic [31:0] ext_data;

    logic   is_load;
    logic   is_store;
    width_e width;
    logic   in_dm;
    logic   in_dev;
    logic   misaligned;
    logic   addr_err;
    logic   issue;

    // Address decode and exception classification for the op in M.
    always_comb begin
        is_load    = (M_MemOp >= OP_LW) && (M_MemOp <= OP_LBU);
        is_store   = (M_MemOp >= OP_SW) && (M_MemOp <= OP_SB);
        width      = op_width(M_MemOp);
        in_dm      = (M_Addr <= DM_LAST);
        in_dev     = (M_Addr >= DEV_BASE) && (M_Addr <= DEV_LAST);
        misaligned = ((width == W_WORD) && (M_Addr[1:0] != 2'b00)) ||
                     ((width == W_HALF) && M_Addr[0]);
        addr_err   = misaligned ||
                     (!in_dm && !in_dev) ||
                     (in_dev && (width != W_WORD)) ||
                     (is_store && ((M_Addr == RO_CNT0) || (M_Addr == RO_CNT1)));
    end

    // An access starts only from IDLE, with a clean address and no flush.
    assign issue = reset && (state == ST_IDLE) && (is_load || is_store) && !addr_err && !Req;

    assign M_ExcAdEL = reset && is_load && addr_err;
    assign M_ExcAdES = reset && is_store && addr_err;
    assign M_Stall   = reset && ((state == ST_BUSY) || (state == ST_DRAIN) || issue);
    assign M_DMRD    = (state == ST_DONE) ? data_q : 32'h0;
    assign state_dbg = state;

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

    mem_load_ext u_load_ext (
        .op    (op_q),
        .addr  (lo_q),
        .rdata (bus.bus_rdata),
        .data  (ext_data)
    );

    // Transfer FSM plus bus and result registers; reset aborts at once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            op_q    <= OP_NONE;
            lo_q    <= 2'b00;
            data_q  <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state   <= ST_BUSY;
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        addr_q  <= {M_Addr[31:2], 2'b00};
                        be_q    <= store_be(M_MemOp, M_Addr[1:0]);
                        wdata_q <= store_data(M_MemOp, M_WData);
                        op_q    <= M_MemOp;
                        lo_q    <= M_Addr[1:0];
                    end
                end
                ST_BUSY: begin
                    if (bus.bus_ack) begin
                        req_q <= 1'b0;
                        if (Req) begin
                            // Flushed in the completing cycle: drop the data.
                            state <= ST_IDLE;
                        end else begin
                            state  <= ST_DONE;
                            data_q <= ext_data;
                        end
                    end else if (Req) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    // Transfer must finish on the bus even though its result is discarded.
                    if (bus.bus_ack) begin
                        req_q <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a scripted bus responder drives acks, expected
// bus payloads and load results are queued at issue and popped on output.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Req = 1'b0;
    logic [3:0]  M_MemOp = OP_NONE;
    logic [31:0] M_Addr = 32'h0;
    logic [31:0] M_WData = 32'h0;
    logic [31:0] M_DMRD;
    logic        M_Stall;
    logic        M_ExcAdEL;
    logic        M_ExcAdES;
    logic [1:0]  state_dbg;

    mem_access_unit_if bus_if ();

    mem_access_unit dut (
        .clk       (clk),
        .reset     (reset),
        .Req       (Req),
        .M_MemOp   (M_MemOp),
        .M_Addr    (M_Addr),
        .M_WData   (M_WData),
        .M_DMRD    (M_DMRD),
        .M_Stall   (M_Stall),
        .M_ExcAdEL (M_ExcAdEL),
        .M_ExcAdES (M_ExcAdES),
        .state_dbg (state_dbg),
        .bus       (bus_if.master)
    );

    // Clock and time limit.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [68:0] bus_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Reference load extraction.
    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = rd >> {a[1:0], 3'b000};
        h = rd >> {a[1], 4'b0000};
        case (op)
            OP_LW:   return rd;
            OP_LH:   return {{16{h[15]}}, h[15:0]};
            OP_LHU:  return {16'h0, h[15:0]};
            OP_LB:   return {{24{b[7]}}, b[7:0]};
            OP_LBU:  return {24'h0, b[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    // Reference bus payload {we, be, addr, wdata}.
    function automatic logic [68:0] model_bus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
        logic       we;
        logic [3:0] be;
        logic [31:0] d;
        we = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
        be = 4'b1111;
        d  = 32'h0;
        if (op == OP_SW) d = wd;
        if (op == OP_SH) begin
            be = a[1] ? 4'b1100 : 4'b0011;
            d  = {wd[15:0], wd[15:0]};
        end
        if (op == OP_SB) begin
            be = 4'b0001 << a[1:0];
            d  = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        end
        return {we, be, a[31:2], 2'b00, d};
    endfunction

    task automatic check_bus(input string tag, input logic [68:0] e);
        check({tag, "_we"},   32'(bus_if.bus_we), 32'(e[68]));
        check({tag, "_be"},   32'(bus_if.bus_be), 32'(e[67:64]));
        check({tag, "_addr"}, bus_if.bus_addr, e[63:32]);
        if (e[68]) check({tag, "_wdata"}, bus_if.bus_wdata, e[31:0]);
    endtask

    // One complete access; ack arrives after ack_wait BUSY cycles without it.
    task automatic do_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int ack_wait);
        logic [68:0] eb;
        int stall_cnt;
        exp_q.push_back(model_load(op, addr, rdata));
        bus_q.push_back(model_bus(op, addr, wdata));
        @(negedge clk);
        M_MemOp = op; M_Addr = addr; M_WData = wdata; bus_if.bus_ack = 1'b0;
        #1;
        check("issue_stall", 32'(M_Stall), 32'd1);
        check("issue_exc", 32'({M_ExcAdEL, M_ExcAdES}), 32'd0);
        check("issue_req", 32'(bus_if.bus_req), 32'd0);
        stall_cnt = 32'(M_Stall);
        eb = bus_q.pop_front();
        for (int k = 0; k <= ack_wait; k++) begin
            @(negedge clk);
            bus_if.bus_ack   = (k == ack_wait);
            bus_if.bus_rdata = (k == ack_wait) ? rdata : $urandom;
            #1;
            stall_cnt += 32'(M_Stall);
            check("busy_req", 32'(bus_if.bus_req), 32'd1);
            check("busy_state", 32'(state_dbg), 32'(S_BUSY));
            check("busy_dmrd", M_DMRD, 32'h0);
            if (k == 0 || k == ack_wait) check_bus("bus", eb);
        end
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        #1;
        check("done_state", 32'(state_dbg), 32'(S_DONE));
        check("done_stall", 32'(M_Stall), 32'd0);
        check("done_req", 32'(bus_if.bus_req), 32'd0);
        check("done_dmrd", M_DMRD, exp_q.pop_front());
        check("stall_cycles", 32'(stall_cnt), 32'(ack_wait + 2));
        @(negedge clk);
        M_MemOp = OP_NONE;
        #1;
        check("after_state", 32'(state_dbg), 32'(S_IDLE));
        check("after_dmrd", M_DMRD, 32'h0);
    endtask

    // Rejected access: exception flags only, no bus activity, no stall.
    task automatic do_exc(input logic [3:0] op, input logic [31:0] addr, input logic exp_l, input logic exp_s);
        @(negedge clk);
        M_MemOp = op; M_Addr = addr; M_WData = 32'hDEAD_BEEF;
        #1;
        check("exc_adel", 32'(M_ExcAdEL), 32'(exp_l));
        check("exc_ades", 32'(M_ExcAdES), 32'(exp_s));
        check("exc_stall", 32'(M_Stall), 32'd0);
        @(negedge clk);
        #1;
        check("exc_req", 32'(bus_if.bus_req), 32'd0);
        check("exc_state", 32'(state_dbg), 32'(S_IDLE));
        M_MemOp = OP_NONE;
    endtask

    logic [3:0] op_tab[8] = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB};

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;

        // Reset with an illegal load applied: everything quiet.
        M_MemOp = OP_LW; M_Addr = 32'h6;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 32'(M_Stall), 32'd0);
        check("rst_exc", 32'({M_ExcAdEL, M_ExcAdES}), 32'd0);
        check("rst_req", 32'(bus_if.bus_req), 32'd0);
        check("rst_addr", bus_if.bus_addr, 32'h0);
        check("rst_be", 32'(bus_if.bus_be), 32'h0);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        check("rst_dmrd", M_DMRD, 32'h0);
        @(negedge clk);
        M_MemOp = OP_NONE; M_Addr = 32'h0; reset = 1'b1;

        // Sign-extended byte load, ack in second BUSY cycle.
        do_access(OP_LB, 32'h0000_0003, 32'h0, 32'h80FF_FF12, 1);
        // Upper-half store.
        do_access(OP_SH, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 0);
        // Read of a read-only counter completes normally.
        do_access(OP_LW, 32'h0000_7F08, 32'h0, 32'h1234_5678, 2);

        // Randomised legal accesses into data memory.
        for (int i = 0; i < 16; i++) begin
            op = op_tab[$urandom_range(0, 7)];
            a  = 32'($urandom_range(0, 32'h2FFF));
            if (op == OP_LW || op == OP_SW) a[1:0] = 2'b00;
            if (op == OP_LH || op == OP_LHU || op == OP_SH) a[0] = 1'b0;
            do_access(op, a, $urandom, $urandom, $urandom_range(0, 3));
        end

        // Exception cases.
        do_exc(OP_LW, 32'h0000_0006, 1'b1, 1'b0);
        do_exc(OP_SW, 32'h0000_3000, 1'b0, 1'b1);
        do_exc(OP_SB, 32'h0000_7F04, 1'b0, 1'b1);
        do_exc(OP_SW, 32'h0000_7F08, 1'b0, 1'b1);
        do_exc(OP_LH, 32'h0000_0001, 1'b1, 1'b0);
        do_exc(OP_LH, 32'h0000_7F00, 1'b1, 1'b0);
        do_exc(OP_SW, 32'h0000_7F18, 1'b0, 1'b1);
        do_exc(4'd9, 32'h0000_0006, 1'b0, 1'b0);

        // Flush in IDLE: no issue.
        @(negedge clk);
        M_MemOp = OP_LW; M_Addr = 32'h10; Req = 1'b1;
        #1;
        check("req_idle_stall", 32'(M_Stall), 32'd0);
        @(negedge clk);
        #1;
        check("req_idle_req", 32'(bus_if.bus_req), 32'd0);
        Req = 1'b0; M_MemOp = OP_NONE;

        // Stray ack while idle is ignored.
        @(negedge clk);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        #1;
        check("stray_ack_state", 32'(state_dbg), 32'(S_IDLE));
        check("stray_ack_dmrd", M_DMRD, 32'h0);

        // Flush while BUSY: drain until ack, result discarded.
        @(negedge clk);
        M_MemOp = OP_LW; M_Addr = 32'h20;
        @(negedge clk);
        Req = 1'b1;
        #1;
        check("drain_busy_req", 32'(bus_if.bus_req), 32'd1);
        @(negedge clk);
        Req = 1'b0; M_MemOp = OP_NONE;
        for (int k = 0; k < 3; k++) begin
            bus_if.bus_ack = (k == 2); bus_if.bus_rdata = 32'hCAFE_F00D;
            #1;
            check("drain_state", 32'(state_dbg), 32'(S_DRAIN));
            check("drain_req", 32'(bus_if.bus_req), 32'd1);
            check("drain_stall", 32'(M_Stall), 32'd1);
            check("drain_dmrd", M_DMRD, 32'h0);
            @(negedge clk);
        end
        bus_if.bus_ack = 1'b0;
        #1;
        check("drain_end_state", 32'(state_dbg), 32'(S_IDLE));
        check("drain_end_req", 32'(bus_if.bus_req), 32'd0);
        check("drain_end_dmrd", M_DMRD, 32'h0);

        // Reset while BUSY aborts the transfer.
        @(negedge clk);
        M_MemOp = OP_SW; M_Addr = 32'h40; M_WData = 32'h5555_AAAA;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy_stall", 32'(M_Stall), 32'd0);
        @(negedge clk);
        reset = 1'b1; M_MemOp = OP_NONE;
        #1;
        check("rst_busy_state", 32'(state_dbg), 32'(S_IDLE));
        check("rst_busy_req", 32'(bus_if.bus_req), 32'd0);
        check("rst_busy_we", 32'(bus_if.bus_we), 32'd0);
        check("rst_busy_be", 32'(bus_if.bus_be), 32'd0);
        check("rst_busy_addr", bus_if.bus_addr, 32'h0);
        check("rst_busy_wdata", bus_if.bus_wdata, 32'h0);
        check("rst_busy_stall2", 32'(M_Stall), 32'd0);

        // Unit still works after the abort.
        do_access(OP_LHU, 32'h0000_0202, 32'h0, 32'h9ABC_1234, 1);

        check("sb_empty", 32'(exp_q.size() + bus_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low; sampled on clk rising edge.
REQ-003 SHALL have port: Req  in  1  exception/interrupt flush of M stage, active-high.
REQ-004 SHALL have port: M_MemOp  in  4  0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; others treated as none.
REQ-005 SHALL have ports: M_Addr  in  32  byte address; M_WData  in  32  store data (low-aligned).
REQ-006 SHALL have port: M_DMRD  out  32  extended load data; feeds M/W pipeline register.
REQ-007 SHALL have port: M_Stall  out  1  freezes F/D/E/M and holds M/W write enable low.
REQ-008 SHALL have ports: M_ExcAdEL, M_ExcAdES  out  1  load/store address exception, combinational.
REQ-009 SHALL have bus ports: bus_req, bus_we  out 1; bus_addr  out 32 (word aligned); bus_be  out 4; bus_wdata  out 32; bus_ack  in 1; bus_rdata  in 32.

Function
REQ-010 SHALL decode legal ranges: DM 0x0000_0000-0x0000_2FFF (any width); device 0x0000_7F00-0x0000_7F1B (word only).
REQ-011 SHALL raise AdEL/AdES (load/store) for: misaligned word (addr[1:0]!=0), misaligned half (addr[0]!=0), out of range, sub-word to device, store to 0x7F08/0x7F18 (read-only counters).
REQ-012 SHALL use states IDLE, BUSY, DONE, DRAIN.
REQ-013 IDLE: valid op, no exception, Req=0 -> BUSY next edge; else remain IDLE, no bus activity.
REQ-014 BUSY: bus_req=1; bus_addr, bus_we, bus_be, bus_wdata registered on IDLE->BUSY and held stable until bus_ack.
REQ-015 BUSY with bus_ack=1 -> DONE; loads capture extended bus_rdata into data register on that edge; bus_req low from next cycle.
REQ-016 DONE: M_DMRD = data register, M_Stall=0; -> IDLE next edge (single-cycle result window).
REQ-017 M_Stall SHALL be 1 in BUSY and DRAIN, and in IDLE when REQ-013 issue conditions hold; 0 otherwise.
REQ-018 Req in BUSY -> DRAIN: bus_req held until bus_ack, data discarded, then IDLE; Req in IDLE/DONE -> IDLE, no issue.
REQ-019 bus_ack SHALL be ignored when bus_req=0; ack in cycle of BUSY entry is not possible (registered req).
REQ-020 SW: be=1111. SH: wdata={2{WData[15:0]}}, be=0011 (addr[1]=0) / 1100. SB: wdata={4{WData[7:0]}}, be one-hot at addr[1:0]. Loads: be=1111, we=0.
REQ-021 Loads SHALL select byte/half by latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend to 32 bits.
REQ-022 M_DMRD SHALL be 0 in every state except DONE.
REQ-023 Exception outputs SHALL be 0 when M_MemOp is none or reset active.

Reset
REQ-024 reset=0 at edge SHALL force IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, data register=0, aborting any BUSY/DRAIN without waiting for ack.
REQ-025 While reset=0, M_Stall, M_ExcAdEL, M_ExcAdES SHALL be 0.

Structure
REQ-026 Op codes, range bounds, read-only addresses and state encoding SHALL live in the shared definitions include.
REQ-027 Load extension SHALL be a combinational sub-module mem_load_ext (inputs op, addr[1:0], rdata).
REQ-028 Address/exception decode SHALL be purely combinational; only FSM, bus registers and data register are sequential.

Verification
REQ-029 LB at 0x0000_0003, bus_rdata=0x80FF_FF12, ack 2 cycles after req -> M_Stall 1 for 3 cycles, DONE M_DMRD=0xFFFF_FF80.
REQ-030 SH at 0x0000_0102, WData=0x0000_ABCD -> bus_addr=0x100, be=1100, wdata=0xABCD_ABCD, we=1; no exception.
REQ-031 LW 0x0000_0006 and SW 0x0000_3000 -> AdEL=1 / AdES=1 respectively, bus_req stays 0, M_Stall 0.
REQ-032 Req asserted in BUSY, ack 3 cycles later -> DRAIN, bus_req held until ack, M_DMRD stays 0, then IDLE.
REQ-033 reset=0 during BUSY -> next cycle IDLE, bus_req=0, all bus outputs 0, M_Stall 0.
REQ-034 SB to 0x0000_7F04 and SW to 0x0000_7F08 -> both AdES=1; LW 0x0000_7F08 completes normally.
